baudgen_rx_ovs: RTL and testbench

Parametrised oversampling baud generator for the UART receive path. It divides the system clock by a runtime-programmable divisor to produce an oversample tick. It counts ticks into bit phases, producing a mid-bit sample strobe, an end-of-bit strobe and a bit index. It sits between the receiver's start-bit detector, which drives `clk_ena` and `resync`, and the receiver's shift register and FSM, which consume `sample_o`, `bit_end_o` and `bit_idx_o`.

---
 rtl/baudgen_rx_ovs_if.sv | 27 ++
 rtl/baudgen_rx_ovs.sv | 85 ++++++++
 tb/tb_baudgen_rx_ovs.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/baudgen_rx_ovs_if.sv
// Bundle between the start-bit detector / receiver FSM and the
// oversampling baud generator. The master drives run control and the
// divisor; the slave (the generator) returns the strobes and status.
interface baudgen_rx_ovs_if #(
    parameter int DIV_W = 16,
    parameter int BIT_W = 4
);
    logic             clk_ena;
    logic             resync;
    logic             div_load;
    logic [DIV_W-1:0] div_i;
    logic             ovs_tick_o;
    logic             sample_o;
    logic             bit_end_o;
    logic [BIT_W-1:0] bit_idx_o;
    logic             cfg_err_o;

    modport master (
        output clk_ena, resync, div_load, div_i,
        input  ovs_tick_o, sample_o, bit_end_o, bit_idx_o, cfg_err_o
    );

    modport slave (
        input  clk_ena, resync, div_load, div_i,
        output ovs_tick_o, sample_o, bit_end_o, bit_idx_o, cfg_err_o
    );
endinterface

// File: rtl/baudgen_rx_ovs.sv
// Oversampling baud generator for the UART receive path.
// Divides clk by a programmable divisor into oversample ticks, groups
// OVS ticks into a bit, and emits registered mid-bit / end-of-bit
// strobes plus a count of completed bits.
module baudgen_rx_ovs #(
    parameter int DIV_W       = 16,
    parameter int OVS         = 16,
    parameter int BIT_W       = 4,
    parameter int DEFAULT_DIV = 27
) (
    input logic               clk,
    input logic               rst,
    baudgen_rx_ovs_if.slave   bus
);
    localparam int               PH_W    = $clog2(OVS);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OVS - 1);
    localparam logic [PH_W-1:0]  PH_MID  = PH_W'(OVS / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] presc;
    logic [PH_W-1:0]  phase;
    logic [BIT_W-1:0] bit_idx;
    logic             cfg_err;
    logic             tick_q;
    logic             sample_q;
    logic             bit_end_q;
    logic             wrap;

    // ">=" rather than "==" so a divisor shrunk below presc wraps at once
    // instead of running presc all the way round 2^DIV_W.
    assign wrap = (presc >= (div_reg - DIV_W'(1)));

    // Divisor register and sticky illegal-load flag; loads apply in any run state.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg <= DIV_RST;
            cfg_err <= 1'b0;
        end else if (bus.div_load) begin
            if (bus.div_i != '0) begin
                div_reg <= bus.div_i;
            end else begin
                cfg_err <= 1'b1;
            end
        end
    end

    // Prescaler, bit phase, bit index and registered strobes.
    always_ff @(posedge clk) begin
        tick_q    <= 1'b0;
        sample_q  <= 1'b0;
        bit_end_q <= 1'b0;
        if (rst) begin
            presc   <= '0;
            phase   <= '0;
            bit_idx <= '0;
        end else if (!bus.clk_ena) begin
            presc   <= '0;
            phase   <= '0;
            bit_idx <= '0;
        end else if (bus.resync) begin
            presc <= '0;
            phase <= '0;
        end else if (wrap) begin
            presc  <= '0;
            tick_q <= 1'b1;
            phase  <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
            if (phase == PH_MID) begin
                sample_q <= 1'b1;
            end
            if (phase == PH_LAST) begin
                bit_end_q <= 1'b1;
                bit_idx   <= bit_idx + BIT_W'(1);
            end
        end else begin
            presc <= presc + DIV_W'(1);
        end
    end

    assign bus.ovs_tick_o = tick_q;
    assign bus.sample_o   = sample_q;
    assign bus.bit_end_o  = bit_end_q;
    assign bus.bit_idx_o  = bit_idx;
    assign bus.cfg_err_o  = cfg_err;
endmodule

// File: tb/tb_baudgen_rx_ovs.sv
// Self-checking bench for baudgen_rx_ovs: directed scenarios with
// explicit edge numbers, then randomized traffic, all compared every
// cycle against a tick-counting reference model.
module tb_baudgen_rx_ovs;
    localparam int DIV_W = 16;
    localparam int OVS   = 16;
    localparam int BIT_W = 4;
    localparam int DEF   = 27;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    baudgen_rx_ovs_if #(.DIV_W(DIV_W), .BIT_W(BIT_W)) bus ();

    baudgen_rx_ovs #(
        .DIV_W(DIV_W), .OVS(OVS), .BIT_W(BIT_W), .DEFAULT_DIV(DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles elapsed in the current tick period, ticks
    // since the last realign, completed bits, divisor and error flag.
    int m_div, m_el, m_ticks, m_bits, m_err;
    bit e_tick, e_samp, e_end;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int old_div;
        old_div = m_div;
        e_tick = 0; e_samp = 0; e_end = 0;
        if (rst) begin
            m_div = DEF; m_err = 0; m_el = 0; m_ticks = 0; m_bits = 0;
        end else begin
            if (bus.div_load) begin
                if (bus.div_i != 0) m_div = int'(bus.div_i);
                else m_err = 1;
            end
            if (!bus.clk_ena) begin
                m_el = 0; m_ticks = 0; m_bits = 0;
            end else if (bus.resync) begin
                m_el = 0; m_ticks = 0;
            end else begin
                m_el++;
                if (m_el >= old_div) begin
                    m_el = 0;
                    e_tick = 1;
                    m_ticks = (m_ticks + 1) % OVS;
                    if (m_ticks == OVS / 2) e_samp = 1;
                    if (m_ticks == 0) begin
                        e_end = 1;
                        m_bits = (m_bits + 1) % (1 << BIT_W);
                    end
                end
            end
        end
    endtask

    // One clock edge: advance the model with the inputs applied at that
    // edge, then compare every output just after it.
    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        check_eq("tick",    32'(bus.ovs_tick_o), 32'(e_tick));
        check_eq("sample",  32'(bus.sample_o),   32'(e_samp));
        check_eq("bit_end", 32'(bus.bit_end_o),  32'(e_end));
        check_eq("bit_idx", 32'(bus.bit_idx_o),  32'(m_bits));
        check_eq("cfg_err", 32'(bus.cfg_err_o),  32'(m_err));
    endtask

    task automatic idle_load(input int d);
        bus.clk_ena = 1'b0; bus.resync = 1'b0;
        bus.div_load = 1'b1; bus.div_i = DIV_W'(d);
        step();
        bus.div_load = 1'b0;
    endtask

    initial begin
        int first_tick, s1, s2, b1, b1_idx;
        int tq[$];
        int ntick;

        bus.clk_ena = 1'b1; bus.resync = 1'b0; bus.div_load = 1'b0; bus.div_i = '0;

        // Reset defaults
        rst = 1'b1;
        step(); step();
        check_eq("rst_tick", 32'(bus.ovs_tick_o), 0);
        check_eq("rst_idx",  32'(bus.bit_idx_o),  0);
        rst = 1'b0; bus.clk_ena = 1'b0;
        step();
        check_eq("idle_out", {28'd0, bus.ovs_tick_o, bus.sample_o, bus.bit_end_o, bus.cfg_err_o}, 0);
        bus.clk_ena = 1'b1;
        first_tick = 0;
        for (int e = 1; e <= 60; e++) begin
            step();
            if (bus.ovs_tick_o && first_tick == 0) first_tick = e;
        end
        check_eq("def_period", first_tick, 27);

        // Nominal period, D=4
        idle_load(4);
        bus.clk_ena = 1'b1;
        first_tick = 0; s1 = 0; s2 = 0; b1 = 0; b1_idx = -1;
        for (int e = 1; e <= 100; e++) begin
            step();
            if (bus.ovs_tick_o && first_tick == 0) first_tick = e;
            if (bus.sample_o) begin
                if (s1 == 0) s1 = e; else if (s2 == 0) s2 = e;
            end
            if (bus.bit_end_o && b1 == 0) begin b1 = e; b1_idx = int'(bus.bit_idx_o); end
        end
        check_eq("nom_tick1", first_tick, 4);
        check_eq("nom_samp1", s1, 32);
        check_eq("nom_end1",  b1, 64);
        check_eq("nom_idx1",  b1_idx, 1);
        check_eq("nom_samp2", s2, 96);

        // Resync at edge 50
        idle_load(4);
        bus.clk_ena = 1'b1;
        first_tick = 0; s1 = 0;
        for (int e = 1; e <= 90; e++) begin
            bus.resync = (e == 50);
            step();
            if (e == 50)
                check_eq("rsync_quiet", {29'd0, bus.ovs_tick_o, bus.sample_o, bus.bit_end_o}, 0);
            if (e > 50 && bus.ovs_tick_o && first_tick == 0) first_tick = e;
            if (e > 50 && bus.sample_o && s1 == 0) s1 = e;
        end
        bus.resync = 1'b0;
        check_eq("rsync_tick", first_tick, 54);
        check_eq("rsync_samp", s1, 82);
        check_eq("rsync_idx",  32'(bus.bit_idx_o), 0);

        // Divisor change mid-count: D=10, load 3 when presc=7
        idle_load(10);
        bus.clk_ena = 1'b1;
        tq.delete();
        for (int e = 1; e <= 16; e++) begin
            bus.div_load = (e == 8);
            bus.div_i    = DIV_W'(3);
            step();
            if (bus.ovs_tick_o) tq.push_back(e);
        end
        bus.div_load = 1'b0;
        check_eq("chg_ntick", tq.size(), 3);
        if (tq.size() == 3) begin
            check_eq("chg_t0", tq[0], 9);
            check_eq("chg_t1", tq[1], 12);
            check_eq("chg_t2", tq[2], 15);
        end

        // Illegal divisor load
        idle_load(4);
        bus.clk_ena = 1'b1;
        ntick = 0;
        for (int e = 1; e <= 40; e++) begin
            bus.div_load = (e == 2);
            bus.div_i    = '0;
            step();
            if (bus.ovs_tick_o) ntick++;
        end
        bus.div_load = 1'b0;
        check_eq("ill_ticks", ntick, 10);
        check_eq("ill_err",   32'(bus.cfg_err_o), 1);

        // Bit index wrap and disable mid-bit, D=1
        idle_load(1);
        bus.clk_ena = 1'b1;
        for (int e = 1; e <= 256; e++) begin
            step();
            if (e == 255) check_eq("wrap_idx15", 32'(bus.bit_idx_o), 15);
        end
        check_eq("wrap_end",  32'(bus.bit_end_o), 1);
        check_eq("wrap_idx0", 32'(bus.bit_idx_o), 0);
        for (int e = 0; e < 24; e++) step();
        check_eq("pre_dis_idx", 32'(bus.bit_idx_o), 1);
        bus.clk_ena = 1'b0;
        for (int e = 0; e < 3; e++) begin
            step();
            check_eq("dis_strobes", {29'd0, bus.ovs_tick_o, bus.sample_o, bus.bit_end_o}, 0);
            check_eq("dis_idx",     32'(bus.bit_idx_o), 0);
        end
        check_eq("err_sticky", 32'(bus.cfg_err_o), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("err_clr", 32'(bus.cfg_err_o), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 599) == 0);
            bus.clk_ena  = ($urandom_range(0, 49) != 0);
            bus.resync   = ($urandom_range(0, 79) == 0);
            bus.div_load = ($urandom_range(0, 39) == 0);
            bus.div_i    = DIV_W'($urandom_range(0, 6));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
